conv_scale: RTL and testbench
=============================

Name: conv_scale

Overview:
- Requantisation stage directly downstream of the convolution accumulator.
- Consumes the final 3x3-accumulated partial sums (the accumulator's scale-channel output, s_sum/s_valid): DN lanes of signed DW-bit values.
- Per lane: fixed-point multiply, rounding right-shift, zero-point add, optional ReLU, saturation to int8.
- Emits packed int8 lanes with a generated output-buffer write address, and a done pulse per tile.

Parameters:
- AW, 11, output buffer address width
- DW, 22, input lane width (signed accumulator sum)
- DN, 6, number of lanes
- SW, 16, scale multiplier width (unsigned)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; latches configuration; honoured only in IDLE
- base  in  AW  first output write address
- size  in  8  number of input beats expected for this tile
- scale  in  SW  unsigned multiplier
- shift  in  5  right-shift amount, 0..31
- zp  in  8  signed output zero point
- relu_en  in  1  1 = clamp the low end at zp
- s_sum  in  DW*DN  signed lane sums; lane i = bits [i*DW +: DW]
- s_valid  in  1  beat valid; no backpressure, every valid beat in RUN is consumed
- o_data  out  8*DN  int8 lanes; lane i = bits [i*8 +: 8]
- o_addr  out  AW  write address for o_data
- o_valid  out  1  write enable
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse at tile end
- drop_err  out  1  sticky; set when s_valid is seen in IDLE or DRAIN; cleared only by rst

Behaviour:
- Reset (synchronous, rst high at posedge):
  - State returns to IDLE.
  - o_data=0, o_addr=0, o_valid=0, busy=0, done=0, drop_err=0.
  - Pipeline valids cleared.
  - Reset mid-tile abandons the tile; no done pulse is produced.
- State machine:
  - IDLE: on start, latch base, size, scale, shift, zp, relu_en and clear the beat counter.
    - size != 0: go to RUN.
    - size == 0: go to DONE.
  - RUN: each s_valid increments the beat counter. On the beat that makes count == size, go to DRAIN.
  - DRAIN: wait until the 3-stage pipeline holds no valid beat, then go to DONE.
  - DONE: assert done for one cycle, then go to IDLE.
- start outside IDLE is ignored.
- s_valid in IDLE or DRAIN is dropped and sets drop_err.
- s_valid together with start in the same IDLE cycle is dropped; the first accepted beat is in the cycle after start.
- Pipeline latency: an accepted beat at cycle t produces o_valid at t+3, with no bubbles.
  - Stage 1: p = s_sum_lane (signed DW) * {1'b0, scale}, kept at full width DW+SW+1.
  - Stage 2: if shift > 0, r = (p + (1 << (shift-1))) >>> shift; else r = p.
    - Round-half-up; the shift is arithmetic (floor).
  - Stage 3: v = r + sign-extended zp.
    - Low bound: lo = relu_en ? max(zp, -128) : -128.
    - Output = clamp(v, lo, 127) as int8.
  - No intermediate truncation before the clamp; widen r to avoid overflow on the zp add.
- Addressing:
  - o_addr = base for the first output of the tile, then +1 per o_valid.
  - Wraps modulo 2^AW.
  - o_addr holds its last value when o_valid is 0.
- done is asserted the cycle after the last o_valid of the tile.
  - Example: size=4, beats in back-to-back cycles t..t+3 give o_valid at t+3..t+6 and done at t+7.
- busy is high in RUN and DRAIN; it is low in IDLE and DONE.
- The latched configuration is stable for the whole tile; changing input config pins mid-tile has no effect.

Test Plan:
- scale=1, shift=0, zp=0, relu_en=0, size=3, sums lane0 = 5, 300, -300 -> o_data lane0 = 5, 127, -128; o_addr = base, base+1, base+2; o_valid 3 cycles after each beat.
- scale=1, shift=1, sums 3, -3, 1 -> outputs 2, -1, 1 (round-half-up, floor shift).
- relu_en=1, zp=10, scale=1, shift=0, sums -50, 20 -> outputs 10, 30; same stimulus with relu_en=0 -> -40, 30.
- base=0x7FF, size=4, back-to-back beats -> o_addr 0x7FF, 0x000, 0x001, 0x002; done exactly one cycle after the 4th o_valid; busy low afterwards.
- size=0 start -> done pulses 2 cycles after start with no o_valid; s_valid while IDLE -> drop_err=1 and held; a second start while busy -> ignored, no address reload.
- Reset asserted mid-tile after 2 of 5 beats -> all outputs 0 the next cycle, no done pulse; a fresh start then runs a full tile correctly from the new base.

Source files
------------

// File: rtl/conv_scale.sv
// Requantisation stage after the convolution accumulator: scales, rounds, offsets and
// saturates DN signed lane sums to int8, and writes them to sequential output-buffer addresses.
module conv_scale #(
    parameter int AW = 11,
    parameter int DW = 22,
    parameter int DN = 6,
    parameter int SW = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [AW-1:0]     base,
    input  logic [7:0]        size,
    input  logic [SW-1:0]     scale,
    input  logic [4:0]        shift,
    input  logic [7:0]        zp,
    input  logic              relu_en,
    input  logic [DW*DN-1:0]  s_sum,
    input  logic              s_valid,
    output logic [8*DN-1:0]   o_data,
    output logic [AW-1:0]     o_addr,
    output logic              o_valid,
    output logic              busy,
    output logic              done,
    output logic              drop_err
);

    localparam int PW = DW + SW + 1;
    localparam int RW = PW + 1;
    localparam int VW = RW + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t               state;
    logic [7:0]           count;
    logic [7:0]           cfg_size;
    logic [SW-1:0]        cfg_scale;
    logic [4:0]           cfg_shift;
    logic signed [7:0]    cfg_zp;
    logic                 cfg_relu;

    logic                 accept;
    logic                 s1_valid;
    logic                 s2_valid;
    logic [AW-1:0]        wr_ptr;

    logic signed [PW-1:0] p1     [DN];
    logic signed [RW-1:0] r2     [DN];
    logic signed [RW-1:0] r_next [DN];
    logic [7:0]           q_next [DN];
    logic signed [RW-1:0] rnd;
    logic signed [VW-1:0] lo;
    logic signed [VW-1:0] v;

    assign accept = (state == RUN) && s_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            cfg_size  <= '0;
            cfg_scale <= '0;
            cfg_shift <= '0;
            cfg_zp    <= '0;
            cfg_relu  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            drop_err  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (s_valid && (state == IDLE || state == DRAIN)) begin
                drop_err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        cfg_size  <= size;
                        cfg_scale <= scale;
                        cfg_shift <= shift;
                        cfg_zp    <= zp;
                        cfg_relu  <= relu_en;
                        count     <= '0;
                        if (size != 8'd0) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (s_valid) begin
                        count <= count + 8'd1;
                        if (count + 8'd1 == cfg_size) begin
                            state <= DRAIN;
                        end
                    end
                end
                // Leaving once stage 1 is empty lines the done pulse up with the cycle after the last write.
                DRAIN: begin
                    if (!s1_valid) begin
                        state <= DONE;
                        busy  <= 1'b0;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            o_valid  <= 1'b0;
            o_data   <= '0;
            o_addr   <= '0;
            wr_ptr   <= '0;
        end else begin
            s1_valid <= accept;
            s2_valid <= s1_valid;
            o_valid  <= s2_valid;
            if (state == IDLE && start) begin
                wr_ptr <= base;
            end else if (s2_valid) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (s2_valid) begin
                o_addr <= wr_ptr;
                for (int i = 0; i < DN; i++) begin
                    o_data[i*8 +: 8] <= q_next[i];
                end
            end
        end
    end

    // Datapath registers carry no reset; the valid bits above qualify them.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < DN; i++) begin
                p1[i] <= PW'($signed(s_sum[i*DW +: DW])) * PW'($signed({1'b0, cfg_scale}));
            end
        end
        if (s1_valid) begin
            for (int i = 0; i < DN; i++) begin
                r2[i] <= r_next[i];
            end
        end
    end

    always_comb begin
        rnd = '0;
        if (cfg_shift != 5'd0) begin
            rnd = RW'(1) <<< (cfg_shift - 5'd1);
        end
        for (int i = 0; i < DN; i++) begin
            r_next[i] = (RW'(p1[i]) + rnd) >>> cfg_shift;
        end
    end

    // With relu the floor is zp itself, which as an int8 is never below -128.
    always_comb begin
        lo = cfg_relu ? VW'(cfg_zp) : VW'(-128);
        v  = '0;
        for (int i = 0; i < DN; i++) begin
            v = VW'(r2[i]) + VW'(cfg_zp);
            if (v > VW'(127)) begin
                q_next[i] = 8'h7F;
            end else if (v < lo) begin
                q_next[i] = lo[7:0];
            end else begin
                q_next[i] = v[7:0];
            end
        end
    end

endmodule

// File: tb/tb_conv_scale.sv
// Scoreboard bench for conv_scale: directed beats push expected lanes, address and arrival
// cycle; a negedge monitor pops and compares each o_valid and done pulse.
module tb_conv_scale;

    localparam int AW = 11;
    localparam int DW = 22;
    localparam int DN = 6;
    localparam int SW = 16;

    typedef int lanes_t [DN];
    typedef struct {
        logic [8*DN-1:0] data;
        logic [AW-1:0]   addr;
        int              cyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [AW-1:0]     base;
    logic [7:0]        size;
    logic [SW-1:0]     scale;
    logic [4:0]        shift;
    logic [7:0]        zp;
    logic              relu_en;
    logic [DW*DN-1:0]  s_sum;
    logic              s_valid;
    logic [8*DN-1:0]   o_data;
    logic [AW-1:0]     o_addr;
    logic              o_valid;
    logic              busy;
    logic              done;
    logic              drop_err;

    int     cyc = 0;
    int     tests = 0;
    int     fails = 0;
    exp_t   exp_q[$];
    int     done_q[$];
    logic [AW-1:0] exp_addr;
    int     last_beat;
    lanes_t in_v;
    lanes_t ex_v;

    conv_scale #(.AW(AW), .DW(DW), .DN(DN), .SW(SW)) dut (
        .clk(clk), .rst(rst), .start(start), .base(base), .size(size),
        .scale(scale), .shift(shift), .zp(zp), .relu_en(relu_en),
        .s_sum(s_sum), .s_valid(s_valid), .o_data(o_data), .o_addr(o_addr),
        .o_valid(o_valid), .busy(busy), .done(done), .drop_err(drop_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input longint act, input longint req);
        tests++;
        if (act != req) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic reportFail(input string name);
        tests++;
        fails++;
        $display("[TB] FAIL %s at cycle %0d", name, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic startTile(input logic [AW-1:0] b, input int sz, input int sc,
                             input int sh, input int z, input logic r);
        base      = b;
        size      = sz[7:0];
        scale     = sc[SW-1:0];
        shift     = sh[4:0];
        zp        = z[7:0];
        relu_en   = r;
        start     = 1'b1;
        exp_addr  = b;
        last_beat = cyc;
        if (sz == 0) done_q.push_back(cyc + 2);
        tick();
        start = 1'b0;
    endtask

    task automatic applyStimulus(input lanes_t sums, input lanes_t expv);
        exp_t e;
        logic [DW*DN-1:0] ps;
        for (int i = 0; i < DN; i++) begin
            ps[i*DW +: DW]  = sums[i][DW-1:0];
            e.data[i*8 +: 8] = expv[i][7:0];
        end
        e.addr = exp_addr;
        e.cyc  = cyc + 3;
        exp_q.push_back(e);
        exp_addr  = exp_addr + 1'b1;
        last_beat = cyc;
        s_sum   = ps;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while ((exp_q.size() > 0 || done_q.size() > 0) && n < 30) begin
            tick();
            n++;
        end
        if (exp_q.size() > 0 || done_q.size() > 0) begin
            reportFail("drain_timeout");
            exp_q.delete();
            done_q.delete();
        end
        tick();
        checkOutput("busy_after_tile", busy, 0);
    endtask

    task automatic endTile();
        done_q.push_back(last_beat + 4);
        waitDrain();
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                reportFail("missing_output");
                e = exp_q.pop_front();
            end
            if (o_valid) begin
                if (exp_q.size() == 0) begin
                    reportFail("unexpected_o_valid");
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("o_data", o_data, e.data);
                    checkOutput("o_addr", o_addr, e.addr);
                    checkOutput("o_valid_cycle", cyc, e.cyc);
                end
            end
            if (done_q.size() > 0 && done_q[0] < cyc) begin
                reportFail("missing_done");
                void'(done_q.pop_front());
            end
            if (done) begin
                if (done_q.size() == 0) reportFail("unexpected_done");
                else checkOutput("done_cycle", cyc, done_q.pop_front());
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        rst = 1'b1; start = 1'b0; base = '0; size = '0; scale = '0; shift = '0;
        zp = '0; relu_en = 1'b0; s_sum = '0; s_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        checkOutput("reset_o_data", o_data, 0);
        checkOutput("reset_o_addr", o_addr, 0);
        checkOutput("reset_o_valid", o_valid, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_drop_err", drop_err, 0);

        $display("[TB] saturation, identity scale");
        startTile(11'h010, 3, 1, 0, 0, 1'b0);
        checkOutput("busy_in_run", busy, 1);
        in_v = '{5, 300, -300, 0, 127, -129};   ex_v = '{5, 127, -128, 0, 127, -128};
        applyStimulus(in_v, ex_v);
        in_v = '{300, -1, 128, -128, 1, 1000};  ex_v = '{127, -1, 127, -128, 1, 127};
        applyStimulus(in_v, ex_v);
        in_v = '{-300, 7, -7, 64, -64, 2};      ex_v = '{-128, 7, -7, 64, -64, 2};
        applyStimulus(in_v, ex_v);
        endTile();

        $display("[TB] round-half-up, shift 1");
        startTile(11'h100, 3, 1, 1, 0, 1'b0);
        in_v = '{3, -3, 1, -1, 2, -2};          ex_v = '{2, -1, 1, 0, 1, -1};
        applyStimulus(in_v, ex_v);
        in_v = '{5, -5, 255, 256, -256, -257};  ex_v = '{3, -2, 127, 127, -128, -128};
        applyStimulus(in_v, ex_v);
        in_v = '{0, 4, -4, 7, -7, 100};         ex_v = '{0, 2, -2, 4, -3, 50};
        applyStimulus(in_v, ex_v);
        endTile();

        $display("[TB] scale 3, shift 2, zp -5");
        startTile(11'h200, 2, 3, 2, -5, 1'b0);
        in_v = '{10, -10, 1, -1, 100, -200};    ex_v = '{3, -12, -4, -6, 70, -128};
        applyStimulus(in_v, ex_v);
        in_v = '{2, -2, 50, 170, -150, 0};      ex_v = '{-3, -6, 33, 123, -117, -5};
        applyStimulus(in_v, ex_v);
        endTile();

        $display("[TB] relu with zp 10, then without");
        startTile(11'h300, 2, 1, 0, 10, 1'b1);
        in_v = '{-50, 20, 117, 118, -128, 0};   ex_v = '{10, 30, 127, 127, 10, 10};
        applyStimulus(in_v, ex_v);
        in_v = '{-10, 0, -9, 1000, -1000, 5};   ex_v = '{10, 10, 10, 127, 10, 15};
        applyStimulus(in_v, ex_v);
        endTile();
        startTile(11'h300, 2, 1, 0, 10, 1'b0);
        in_v = '{-50, 20, 117, 118, -128, 0};   ex_v = '{-40, 30, 127, 127, -118, 10};
        applyStimulus(in_v, ex_v);
        in_v = '{-10, 0, -9, 1000, -1000, 5};   ex_v = '{0, 10, 1, 127, -128, 15};
        applyStimulus(in_v, ex_v);
        endTile();
        startTile(11'h320, 1, 1, 0, -20, 1'b1);
        in_v = '{-50, 0, 200, -100, 5, -128};   ex_v = '{-20, -20, 127, -20, -15, -20};
        applyStimulus(in_v, ex_v);
        endTile();

        $display("[TB] address wrap, ignored start and config change mid-tile");
        startTile(11'h7FF, 4, 1, 0, 0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            if (k == 2) begin
                start = 1'b1; base = 11'h055; size = 8'd0; scale = '0;
                shift = 5'd7; zp = 8'h9C; relu_en = 1'b1;
            end
            in_v = '{k, k + 1, -k, -k - 1, 100, -100};
            ex_v = in_v;
            applyStimulus(in_v, ex_v);
            start = 1'b0;
        end
        endTile();

        $display("[TB] drop_err and empty tile");
        checkOutput("drop_err_clear", drop_err, 0);
        s_sum = '0;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        checkOutput("drop_err_set", drop_err, 1);
        tick();
        tick();
        tick();
        checkOutput("drop_err_held", drop_err, 1);
        startTile(11'h444, 0, 1, 0, 0, 1'b0);
        checkOutput("busy_size0", busy, 0);
        waitDrain();

        $display("[TB] full-scale values, beat alongside start dropped");
        s_sum = {DN{22'h1FFFFF}};
        s_valid = 1'b1;
        startTile(11'h010, 1, 65535, 31, 0, 1'b0);
        in_v = '{2097151, -2097152, 0, 1000000, -1000000, 32768};
        ex_v = '{64, -64, 0, 31, -31, 1};
        applyStimulus(in_v, ex_v);
        endTile();

        $display("[TB] reset mid-tile");
        startTile(11'h050, 5, 1, 0, 0, 1'b0);
        in_v = '{1, 2, 3, 4, 5, 6};
        applyStimulus(in_v, in_v);
        applyStimulus(in_v, in_v);
        rst = 1'b1;
        exp_q.delete();
        done_q.delete();
        tick();
        rst = 1'b0;
        checkOutput("midreset_o_data", o_data, 0);
        checkOutput("midreset_o_addr", o_addr, 0);
        checkOutput("midreset_o_valid", o_valid, 0);
        checkOutput("midreset_busy", busy, 0);
        checkOutput("midreset_done", done, 0);
        checkOutput("midreset_drop_err", drop_err, 0);
        for (int k = 0; k < 8; k++) tick();
        startTile(11'h600, 2, 1, 0, 0, 1'b0);
        in_v = '{9, -9, 90, -90, 127, -128};     ex_v = '{9, -9, 90, -90, 127, -128};
        applyStimulus(in_v, ex_v);
        in_v = '{129, -129, 0, 1, -1, 50};       ex_v = '{127, -128, 0, 1, -1, 50};
        applyStimulus(in_v, ex_v);
        endTile();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
